// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory initiator: access-size encoding,
// load/store FSM states and the alignment check.
package mips_mem_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } lsu_state_e;

    // True when the access cannot be served by a single aligned lane.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic for sub-word accesses.
// Ports:
//   size_i     access size (SZ_BYTE/SZ_HALF/SZ_WORD)
//   off_i      byte offset within the word (addr[1:0])
//   unsigned_i zero-extend loads instead of sign-extending
//   rword_i    word read from RAM
//   wdata_i    right-justified store data
//   merged_o   rword_i with the selected lane(s) replaced by wdata_i
//   extract_o  selected lane, extended to 32 bits
module lsu_lane_align
    import mips_mem_pkg::*;
(
    input  logic [1:0]      size_i,
    input  logic [1:0]      off_i,
    input  logic            unsigned_i,
    input  logic [XLEN-1:0] rword_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] merged_o,
    output logic [XLEN-1:0] extract_o
);

    logic [4:0]      shamt;
    logic [XLEN-1:0] lane_mask;
    logic [XLEN-1:0] shifted;

    // Halves are only ever at offset 0 or 2, so one byte-granular shift serves both.
    assign shamt   = {off_i, 3'b000};
    assign shifted = rword_i >> shamt;

    always_comb begin
        lane_mask = '1;
        case (size_i)
            SZ_BYTE: lane_mask = XLEN'(32'h0000_00FF) << shamt;
            SZ_HALF: lane_mask = XLEN'(32'h0000_FFFF) << shamt;
            default: lane_mask = '1;
        endcase
    end

    assign merged_o = (rword_i & ~lane_mask) | ((wdata_i << shamt) & lane_mask);

    always_comb begin
        extract_o = rword_i;
        case (size_i)
            SZ_BYTE: extract_o = unsigned_i ? {24'h000000, shifted[7:0]}
                                            : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: extract_o = unsigned_i ? {16'h0000, shifted[15:0]}
                                            : {{16{shifted[15]}}, shifted[15:0]};
            default: extract_o = rword_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, word RAM accesses,
// read-modify-write for byte/half stores, misaligned requests rejected.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   req_valid/req_ready                request handshake from EX/MEM
//   req_we/req_size/req_unsigned       store flag, access size, zero-extend
//   req_addr/req_wdata                 byte address, right-justified store data
//   resp_valid/resp_err/resp_rdata     one-cycle completion, error, load data
//   mem_we/mem_addr/mem_din/mem_dout   word RAM port (RAM samples on falling edge)
module load_store_unit
    import mips_mem_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic            resp_err,
    output logic [XLEN-1:0] resp_rdata,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_din,
    input  logic [XLEN-1:0] mem_dout
);

    lsu_state_e      state_q, state_d;
    logic            we_q, we_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [1:0]      off_q, off_d;
    logic [XLEN-1:0] wdata_q, wdata_d;

    logic            req_ready_q, req_ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic            resp_err_q, resp_err_d;
    logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
    logic            mem_we_q, mem_we_d;
    logic [XLEN-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0] mem_din_q, mem_din_d;

    logic [XLEN-1:0] merged_c;
    logic [XLEN-1:0] extract_c;

    // Lane logic works directly on mem_dout during READ, so no read buffer is needed.
    lsu_lane_align u_align (
        .size_i     (size_q),
        .off_i      (off_q),
        .unsigned_i (uns_q),
        .rword_i    (mem_dout),
        .wdata_i    (wdata_q),
        .merged_o   (merged_c),
        .extract_o  (extract_c)
    );

    // Next-state and registered-output decode.
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        wdata_d      = wdata_q;
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    off_d   = req_addr[1:0];
                    wdata_d = req_wdata;
                    if (is_misaligned(req_size, req_addr[1:0])) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else if (req_we && (req_size == SZ_WORD)) begin
                        state_d    = ST_WRITE;
                        mem_we_d   = 1'b1;
                        mem_addr_d = {req_addr[XLEN-1:2], 2'b00};
                        mem_din_d  = req_wdata;
                    end else begin
                        state_d    = ST_READ;
                        mem_addr_d = {req_addr[XLEN-1:2], 2'b00};
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            ST_READ: begin
                if (we_q) begin
                    state_d   = ST_WRITE;
                    mem_we_d  = 1'b1;
                    mem_din_d = merged_c;
                end else begin
                    state_d      = ST_RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = extract_c;
                end
            end
            ST_WRITE: begin
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
            end
            ST_RESP: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
            default: begin
                state_d     = ST_IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            we_q         <= 1'b0;
            size_q       <= SZ_BYTE;
            uns_q        <= 1'b0;
            off_q        <= 2'b00;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a falling-edge word RAM model.
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    logic [31:0] ram [0:1023];
    int          wcnt;
    logic [31:0] waddr;
    logic [31:0] wdin;

    int n_checks;
    int n_fail;

    load_store_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: samples on the falling edge, registered read data.
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            ram[mem_addr[11:2]] <= mem_din;
            wcnt  = wcnt + 1;
            waddr = mem_addr;
            wdin  = mem_din;
        end else begin
            mem_dout <= ram[mem_addr[11:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          output int lat, output logic err, output logic [31:0] rd);
        int n;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        err = resp_err;
        rd  = resp_rdata;
    endtask

    task automatic chk_req(input string tag, input logic we, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] wd,
                           input int exp_lat, input logic exp_err, input logic [31:0] exp_rd);
        int          lat;
        logic        err;
        logic [31:0] rd;
        do_req(we, sz, uns, a, wd, lat, err, rd);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_err"}, {31'h0, err}, {31'h0, exp_err});
        check({tag, "_rdata"}, rd, exp_rd);
    endtask

    initial begin
        int w0;
        n_checks     = 0;
        n_fail       = 0;
        wcnt         = 0;
        waddr        = '0;
        wdin         = '0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;

        repeat (3) @(negedge clk);
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_resp_err", {31'h0, resp_err}, 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_din", mem_din, 32'h0);
        rst_n = 1'b1;

        // Word store then word load
        chk_req("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h0);
        check("sw10_wcnt", 32'(wcnt), 32'd1);
        check("sw10_waddr", waddr, 32'h10);
        check("sw10_wdin", wdin, 32'hDEADBEEF);
        chk_req("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'hDEADBEEF);
        check("lw10_wcnt", 32'(wcnt), 32'd1);

        // Byte store read-modify-write (upper wdata bits must be ignored)
        chk_req("sw20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 2, 1'b0, 32'h0);
        chk_req("sb21", 1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFFAA, 3, 1'b0, 32'h0);
        check("sb21_waddr", waddr, 32'h20);
        check("sb21_wdin", wdin, 32'h1122AA44);
        chk_req("sh22", 1'b1, 2'b01, 1'b0, 32'h22, 32'h12345566, 3, 1'b0, 32'h0);
        check("sh22_wdin", wdin, 32'h5566AA44);
        chk_req("lw20", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 2, 1'b0, 32'h5566AA44);

        // Load extraction and extension
        chk_req("sw30", 1'b1, 2'b10, 1'b0, 32'h30, 32'h80FF7F01, 2, 1'b0, 32'h0);
        chk_req("lb30", 1'b0, 2'b00, 1'b0, 32'h30, 32'h0, 2, 1'b0, 32'h00000001);
        chk_req("lb31", 1'b0, 2'b00, 1'b0, 32'h31, 32'h0, 2, 1'b0, 32'h0000007F);
        chk_req("lb32", 1'b0, 2'b00, 1'b0, 32'h32, 32'h0, 2, 1'b0, 32'hFFFFFFFF);
        chk_req("lbu32", 1'b0, 2'b00, 1'b1, 32'h32, 32'h0, 2, 1'b0, 32'h000000FF);
        chk_req("lh32", 1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 2, 1'b0, 32'hFFFF80FF);
        chk_req("lhu32", 1'b0, 2'b01, 1'b1, 32'h32, 32'h0, 2, 1'b0, 32'h000080FF);
        chk_req("lh30", 1'b0, 2'b01, 1'b0, 32'h30, 32'h0, 2, 1'b0, 32'h00007F01);
        chk_req("lwu30", 1'b0, 2'b10, 1'b1, 32'h30, 32'h0, 2, 1'b0, 32'h80FF7F01);

        // Misaligned and illegal size
        w0 = wcnt;
        chk_req("sh13", 1'b1, 2'b01, 1'b0, 32'h13, 32'hFFFF, 1, 1'b1, 32'h0);
        chk_req("lw22", 1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 1, 1'b1, 32'h0);
        chk_req("sz11", 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 1, 1'b1, 32'h0);
        check("misal_wcnt", 32'(wcnt), 32'(w0));
        chk_req("lw10b", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 1'b0, 32'hDEADBEEF);

        // Back-to-back with req_valid held high
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h50; req_wdata = 32'hCAFEF00D;
        check("b2b_ready0", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        check("b2b_write_ready", {31'h0, req_ready}, 32'h0);
        check("b2b_write_we", {31'h0, mem_we}, 32'h1);
        req_we = 1'b0; req_wdata = 32'h0;
        @(negedge clk);
        check("b2b_resp1_valid", {31'h0, resp_valid}, 32'h1);
        check("b2b_resp1_ready", {31'h0, req_ready}, 32'h0);
        check("b2b_resp1_we", {31'h0, mem_we}, 32'h0);
        @(negedge clk);
        check("b2b_idle_ready", {31'h0, req_ready}, 32'h1);
        check("b2b_idle_valid", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        check("b2b_read_ready", {31'h0, req_ready}, 32'h0);
        req_valid = 1'b0;
        @(negedge clk);
        check("b2b_resp2_valid", {31'h0, resp_valid}, 32'h1);
        check("b2b_resp2_rdata", resp_rdata, 32'hCAFEF00D);

        // Reset asserted during the WRITE of a byte store
        chk_req("sw40", 1'b1, 2'b10, 1'b0, 32'h40, 32'h01020304, 2, 1'b0, 32'h0);
        w0 = wcnt;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h41; req_wdata = 32'h99;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rstw_we_before", {31'h0, mem_we}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rstw_mem_we", {31'h0, mem_we}, 32'h0);
        check("rstw_req_ready", {31'h0, req_ready}, 32'h1);
        check("rstw_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rstw_mem_addr", mem_addr, 32'h0);
        check("rstw_mem_din", mem_din, 32'h0);
        @(negedge clk);
        check("rstw_wcnt", 32'(wcnt), 32'(w0));
        rst_n = 1'b1;
        chk_req("lw40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 2, 1'b0, 32'h01020304);
        chk_req("lbu41", 1'b0, 2'b00, 1'b1, 32'h41, 32'h0, 2, 1'b0, 32'h00000003);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
